tdm_channel_mux: RTL and testbench

- Parametrised, registered N:1 channel multiplexer. It is the sequential successor to the team's combinational 4:1 and 16:1 muxes.
- Two modes:
  - manual: the channel is chosen by the sel_in port.
  - auto-scan: round-robin over enabled channels, with a programmable dwell time between samples.
- Each sample goes out with a valid/ready handshake and a channel tag.
- Sits between parallel sensor/ADC lanes and a single serial consumer (UART/display/logger).

---
 rtl/tdm_mux_pkg.sv | 13 +
 rtl/rr_next_ch.sv | 34 +++
 rtl/tdm_channel_mux.sv | 140 ++++++++++++++
 tb/tb_tdm_channel_mux.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_mux_pkg.sv
// tdm_mux_pkg: shared state encoding and defaults for the TDM channel multiplexer.
package tdm_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        HOLD   = 2'd2,
        DWELL  = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_DWELL = 4;

endpackage

// File: rtl/rr_next_ch.sv
// rr_next_ch: next set bit of mask strictly above cur, wrapping to the lowest set bit.
module rr_next_ch #(
    parameter int NUM_CH = 16,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [SEL_W-1:0]  cur_i,
    output logic [SEL_W-1:0]  next_o,
    output logic              wrap_o,
    output logic              any_o
);

    logic [SEL_W-1:0] lo;
    logic [SEL_W-1:0] hi;
    logic             found;

    // Descending scan so the last hit is the lowest qualifying index.
    always_comb begin
        lo    = '0;
        hi    = '0;
        found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i]) lo = SEL_W'(i);
            if (mask_i[i] && i > int'(cur_i)) begin
                hi    = SEL_W'(i);
                found = 1'b1;
            end
        end
        any_o  = |mask_i;
        wrap_o = any_o && !found;
        next_o = found ? hi : (any_o ? lo : cur_i);
    end

endmodule

// File: rtl/tdm_channel_mux.sv
// tdm_channel_mux: registered N:1 channel mux with manual select or round-robin scan,
// emitting tagged samples over a valid/ready handshake.
module tdm_channel_mux
    import tdm_mux_pkg::*;
#(
    parameter int NUM_CH  = 16,
    parameter int DATA_W  = 8,
    parameter int DWELL_W = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [DWELL_W-1:0]       dwell,
    input  logic [NUM_CH*DATA_W-1:0] din,
    output logic [DATA_W-1:0]        dout,
    output logic [SEL_W-1:0]         dout_ch,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     scan_wrap
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   cur_ch_q, cur_ch_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic [SEL_W-1:0]   dout_ch_q, dout_ch_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;
    logic [SEL_W-1:0]   sel_ch, smp_ch, rr_cur, rr_next;
    logic               rr_wrap, rr_any, hs;

    assign sel_ch = (int'(sel_in) < NUM_CH) ? sel_in : '0;
    assign smp_ch = mode ? cur_ch_q : sel_ch;
    // From IDLE, asking for the successor of the top index yields the lowest set bit.
    assign rr_cur = (state_q == IDLE) ? SEL_W'(NUM_CH - 1) : cur_ch_q;
    assign hs     = valid_q && dout_ready;

    rr_next_ch #(.NUM_CH(NUM_CH)) u_rr (
        .mask_i (ch_mask),
        .cur_i  (rr_cur),
        .next_o (rr_next),
        .wrap_o (rr_wrap),
        .any_o  (rr_any)
    );

    always_comb begin
        state_d   = state_q;
        cur_ch_d  = cur_ch_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        dout_ch_d = dout_ch_q;
        valid_d   = valid_q;
        wrap_d    = 1'b0;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (en && mode && !rr_any) begin
                    state_d = DWELL;
                    cnt_d   = DWELL_W'(1);
                end else if (en) begin
                    state_d  = SAMPLE;
                    cur_ch_d = mode ? rr_next : cur_ch_q;
                end
            end
            SAMPLE: begin
                dout_d    = din[smp_ch*DATA_W +: DATA_W];
                dout_ch_d = smp_ch;
                valid_d   = 1'b1;
                state_d   = HOLD;
            end
            HOLD: begin
                if (hs) begin
                    valid_d = 1'b0;
                    if (!en) begin
                        state_d = IDLE;
                    end else if (!mode) begin
                        state_d = SAMPLE;
                    end else if (dwell != '0) begin
                        cnt_d   = dwell;
                        state_d = DWELL;
                    end else if (!rr_any) begin
                        cnt_d   = DWELL_W'(1);
                        state_d = DWELL;
                    end else begin
                        cur_ch_d = rr_next;
                        wrap_d   = rr_wrap;
                        state_d  = SAMPLE;
                    end
                end
            end
            DWELL: begin
                // An empty scan mask parks here at count 1 until a channel is enabled.
                if (!en) begin
                    state_d = IDLE;
                end else if (cnt_q > DWELL_W'(1)) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (!mode) begin
                    state_d = SAMPLE;
                end else if (rr_any) begin
                    cur_ch_d = rr_next;
                    wrap_d   = rr_wrap;
                    state_d  = SAMPLE;
                end else begin
                    cnt_d = DWELL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_ch_q  <= '0;
            cnt_q     <= '0;
            dout_q    <= '0;
            dout_ch_q <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_ch_q  <= cur_ch_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            dout_ch_q <= dout_ch_d;
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
        end
    end

    assign dout       = dout_q;
    assign dout_ch    = dout_ch_q;
    assign dout_valid = valid_q;
    assign scan_wrap  = wrap_q;

endmodule

// File: tb/tb_tdm_channel_mux.sv
// tb_tdm_channel_mux: randomized and directed checks of tdm_channel_mux against a
// transaction-level model of the expected sample stream.
module tb_tdm_channel_mux;
    import tdm_mux_pkg::*;

    localparam int N  = 16;
    localparam int W  = 8;
    localparam int DW = 8;

    logic         clk = 1'b0, rst_n = 1'b0, en = 1'b0, mode = 1'b0, dout_ready = 1'b0;
    logic [3:0]   sel_in = '0;
    logic [N-1:0] ch_mask = '0;
    logic [DW-1:0] dwell = '0;
    logic [N*W-1:0] din = '0;
    logic [W-1:0] dout, dout12;
    logic [3:0]   dout_ch, dout_ch12;
    logic         dout_valid, scan_wrap, valid12, wrap12;

    int n_vec = 0, n_err = 0;
    int m_ptr = 0, m_gap = 2;
    bit m_wrap = 1'b0, chk12 = 1'b0;

    always #5 clk = ~clk;

    tdm_channel_mux #(.NUM_CH(N), .DATA_W(W), .DWELL_W(DW)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in),
        .ch_mask(ch_mask), .dwell(dwell), .din(din), .dout(dout), .dout_ch(dout_ch),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .scan_wrap(scan_wrap)
    );

    tdm_channel_mux #(.NUM_CH(12), .DATA_W(W), .DWELL_W(DW)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in),
        .ch_mask(ch_mask[11:0]), .dwell(dwell), .din(din[12*W-1:0]), .dout(dout12),
        .dout_ch(dout_ch12), .dout_valid(valid12), .dout_ready(dout_ready), .scan_wrap(wrap12)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) if (m[i]) return i;
        return 0;
    endfunction

    // Cyclic search for the next enabled channel after cur.
    function automatic int nxt(input logic [N-1:0] m, input int cur);
        for (int k = 1; k <= N; k++) if (m[(cur + k) % N]) return (cur + k) % N;
        return cur;
    endfunction

    function automatic int clamp12(input int s);
        return (s < 12) ? s : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        dout_ready = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_valid(input string tag);
        int b = 0;
        while (!dout_valid && b < 30) begin
            step();
            b++;
        end
        check(tag, dout_valid, 1);
    endtask

    // rp: 0 = ready always high, 1 = random ready, 2 = stall 10 cycles per sample.
    task automatic run(input int n, input int rp);
        int got = 0, budget = 0, g = 0, held = 0, ec = 0, p = 0;
        bit hold = 1'b0, seen = 1'b0;
        logic [W-1:0] hd = '0;
        logic [3:0]   hc = '0;
        while (got < n && budget < 1000) begin
            step();
            budget++;
            g++;
            if (scan_wrap) seen = 1'b1;
            if (dout_valid && !hold) begin
                ec = mode ? m_ptr : int'(sel_in);
                check("gap", g, m_gap);
                check("ch", dout_ch, ec);
                check("data", dout, din[ec*W +: W]);
                check("wrap", seen, m_wrap);
                if (chk12) begin
                    check("ch12", dout_ch12, clamp12(int'(sel_in)));
                    check("data12", dout12, din[clamp12(int'(sel_in))*W +: W]);
                end
                hold = 1'b1;
                seen = 1'b0;
                held = 0;
                hd = dout;
                hc = dout_ch;
            end else if (hold) begin
                check("stall_v", dout_valid, 1);
                check("stall_d", dout, hd);
                check("stall_ch", dout_ch, hc);
                held++;
            end
            dout_ready = (rp == 0) ? 1'b1 : (rp == 1) ? 1'($urandom_range(0, 1)) : (held >= 10);
            if (dout_valid && dout_ready) begin
                got++;
                hold = 1'b0;
                g = 0;
                if (mode) begin
                    p = m_ptr;
                    m_ptr = nxt(ch_mask, p);
                    m_wrap = (m_ptr <= p);
                    m_gap = int'(dwell) + 2;
                end else begin
                    m_wrap = 1'b0;
                    m_gap = 2;
                end
            end
        end
        check("done", got, n);
    endtask

    initial begin
        do_reset();
        check("rst_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_ch", dout_ch, 0);
        check("rst_wrap", scan_wrap, 0);

        // Manual select with per-channel signature data.
        for (int k = 0; k < N; k++) din[k*W +: W] = 8'hA0 + 8'(k);
        mode = 1'b0;
        chk12 = 1'b1;
        m_gap = 2;
        m_wrap = 1'b0;
        sel_in = 4'd5;
        en = 1'b1;
        run(3, 0);
        sel_in = 4'd12;
        run(3, 0);
        sel_in = 4'hF;
        run(2, 0);
        run(2, 2);
        run(4, 1);
        step();

        // Asynchronous reset while a sample is pending.
        dout_ready = 1'b0;
        wait_valid("rst_pre_v");
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", dout_valid, 0);
        check("arst_dout", dout, 0);
        check("arst_ch", dout_ch, 0);
        check("arst_wrap", scan_wrap, 0);
        check("arst_v12", valid12, 0);
        check("arst_w12", wrap12, 0);
        en = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_valid", dout_valid, 0);
        end
        chk12 = 1'b0;

        // Scan over channels 0, 3, 7.
        mode = 1'b1;
        ch_mask = 16'h0089;
        dwell = 8'd3;
        m_ptr = lowest(ch_mask);
        m_wrap = 1'b0;
        m_gap = 2;
        en = 1'b1;
        run(6, 0);

        // Empty mask parks the scan; one enabled channel then repeats with wraps.
        do_reset();
        mode = 1'b1;
        ch_mask = '0;
        dwell = DW'(DEFAULT_DWELL);
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("nomask_v", dout_valid, 0);
        end
        ch_mask = 16'h0400;
        m_ptr = nxt(ch_mask, 0);
        m_wrap = (m_ptr <= 0);
        m_gap = 2;
        run(4, 0);
        step();

        // Drop en while stalled: pending sample survives, then IDLE.
        dout_ready = 1'b0;
        wait_valid("endrop_pre_v");
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("endrop_v", dout_valid, 1);
            check("endrop_ch", dout_ch, 10);
        end
        dout_ready = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            check("endrop_idle", dout_valid, 0);
            step();
        end

        // Randomized trials in both modes.
        for (int t = 0; t < 8; t++) begin
            do_reset();
            for (int k = 0; k < N; k++) din[k*W +: W] = W'($urandom);
            mode = 1'($urandom_range(0, 1));
            chk12 = !mode;
            sel_in = 4'($urandom);
            ch_mask = N'($urandom_range(1, 65535));
            dwell = DW'($urandom_range(0, 3));
            m_ptr = lowest(ch_mask);
            m_wrap = 1'b0;
            m_gap = 2;
            en = 1'b1;
            run(8, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
